// File: rtl/gpc_607_5_if.sv
// Handshake bundle for the (6,0,7;5) generalized parallel counter.
// Inputs are qualified by in_valid; results by out_valid.
interface gpc_607_5_if;
  logic       in_valid;
  logic [6:0] src0;
  logic [5:0] src2;
  logic       out_valid;
  logic [4:0] dst;

  modport master (
    output in_valid, src0, src2,
    input  out_valid, dst
  );

  modport slave (
    input  in_valid, src0, src2,
    output out_valid, dst
  );
endinterface

// File: rtl/gpc_607_5.sv
// Registered (6,0,7;5) GPC: dst = popcount(src0) + 4*popcount(src2).
// PIPE_STAGES=2 adds a register on the intermediate popcounts.
module gpc_607_5 #(
  parameter int PIPE_STAGES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  gpc_607_5_if.slave  bus
);

  function automatic logic [1:0] fa(
    input logic a,
    input logic b,
    input logic c
  );
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  // 7:3 counter from four full adders
  function automatic logic [2:0] cnt7(input logic [6:0] x);
    logic [1:0] f1, f2, f3, f4;
    f1 = fa(x[0], x[1], x[2]);
    f2 = fa(x[3], x[4], x[5]);
    f3 = fa(f1[0], f2[0], x[6]);
    f4 = fa(f1[1], f2[1], f3[1]);
    return {f4[1], f4[0], f3[0]};
  endfunction

  logic [2:0] pc0, pc2;
  logic [2:0] q0, q2;
  logic       qv;
  logic [4:0] sum;

  assign pc0 = cnt7(bus.src0);
  assign pc2 = cnt7({1'b0, bus.src2});

  if (PIPE_STAGES == 2) begin : g_mid
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        qv <= 1'b0;
        q0 <= '0;
        q2 <= '0;
      end else begin
        qv <= bus.in_valid;
        if (bus.in_valid) begin
          q0 <= pc0;
          q2 <= pc2;
        end
      end
    end
  end else if (PIPE_STAGES == 1) begin : g_direct
    assign qv = bus.in_valid;
    assign q0 = pc0;
    assign q2 = pc2;
  end else begin : g_bad
    $error("gpc_607_5: PIPE_STAGES must be 1 or 2");
  end

  assign sum = {q2, 2'b00} + {2'b00, q0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.dst       <= '0;
    end else begin
      bus.out_valid <= qv;
      if (qv) bus.dst <= sum;
    end
  end

endmodule

// File: tb/tb_gpc_607_5.sv
// Self-checking bench for gpc_607_5 at PIPE_STAGES 1 and 2.
// Reference keeps the sampled input history and derives expected outputs.
module tb_gpc_607_5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [6:0] src0;
  logic [5:0] src2;

  int nvec = 0;
  int nerr = 0;

  bit         smp_v[$];
  logic [4:0] smp_d[$];

  gpc_607_5_if u_if1 ();
  gpc_607_5_if u_if2 ();

  assign u_if1.in_valid = in_valid;
  assign u_if1.src0     = src0;
  assign u_if1.src2     = src2;
  assign u_if2.in_valid = in_valid;
  assign u_if2.src0     = src0;
  assign u_if2.src2     = src2;

  gpc_607_5 #(.PIPE_STAGES(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if1.slave)
  );

  gpc_607_5 #(.PIPE_STAGES(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if2.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] wsum(
    input logic [6:0] a,
    input logic [5:0] b
  );
    int s;
    s = $countones(a) + 4 * $countones(b);
    return 5'(s);
  endfunction

  task automatic chk(input string tag, input logic [4:0] obs,
                     input logic [4:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs for an n-cycle latency, from the sample history
  task automatic model(input int n, output logic ev, output logic [4:0] ed);
    int idx;
    idx = smp_v.size() - n;
    ev = 1'b0;
    ed = 5'd0;
    if (idx >= 0) begin
      ev = smp_v[idx];
      for (int i = idx; i >= 0; i--) begin
        if (smp_v[i]) begin
          ed = smp_d[i];
          break;
        end
      end
    end
  endtask

  task automatic check_all();
    logic       ev;
    logic [4:0] ed;
    model(1, ev, ed);
    chk("p1_valid", {4'd0, u_if1.out_valid}, {4'd0, ev});
    chk("p1_dst", u_if1.dst, ed);
    model(2, ev, ed);
    chk("p2_valid", {4'd0, u_if2.out_valid}, {4'd0, ev});
    chk("p2_dst", u_if2.dst, ed);
  endtask

  task automatic step(input bit v, input logic [6:0] a,
                      input logic [5:0] b);
    in_valid = v;
    src0     = a;
    src2     = b;
    @(posedge clk);
    if (rst_n) begin
      smp_v.push_back(v);
      smp_d.push_back(wsum(a, b));
    end
    #1;
    check_all();
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    src0     = '0;
    src2     = '0;
    #12;
    check_all();
    rst_n = 1'b1;

    step(1, 7'h30, 6'h2b);
    chk("basic", u_if1.dst, 5'h12);
    step(1, 7'h7f, 6'h3f);
    chk("all_ones", u_if1.dst, 5'h1f);
    step(1, 7'h00, 6'h00);
    chk("all_zero", u_if1.dst, 5'h00);
    step(1, 7'h1b, 6'h00);
    chk("ones_only", u_if1.dst, 5'h04);

    step(1, 7'h62, 6'h0e);
    chk("stream_a", u_if1.dst, 5'h0f);
    step(1, 7'h5e, 6'h2f);
    chk("stream_b", u_if1.dst, 5'h19);
    chk("stream_a_p2", u_if2.dst, 5'h0f);
    step(0, 7'h00, 6'h00);
    chk("stream_b_p2", u_if2.dst, 5'h19);

    step(1, 7'h30, 6'h2b);
    step(0, 7'h7f, 6'h3f);
    chk("gate_hold", u_if1.dst, 5'h12);
    chk("gate_ov", {4'd0, u_if1.out_valid}, 5'd0);

    // mid-stream asynchronous reset
    step(1, 7'h7f, 6'h3f);
    in_valid = 1'b1;
    src0     = 7'h55;
    src2     = 6'h2a;
    #2;
    rst_n = 1'b0;
    #1;
    smp_v.delete();
    smp_d.delete();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    step(0, 7'h7f, 6'h3f);
    step(0, 7'h7f, 6'h3f);
    step(0, 7'h7f, 6'h3f);

    for (int i = 0; i < 8192; i++) begin
      logic [12:0] v;
      v = 13'(i);
      step(1, v[6:0], v[12:7]);
    end

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 7'($urandom), 6'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/gpc_607_5.md
Name: gpc_607_5

Overview:
- Registered (6,0,7;5) generalized parallel counter for compressor trees in multi-operand adders.
- Counts 7 bits of weight 1 and 6 bits of weight 4; weight-2 column is empty.
- Produces their weighted sum as a 5-bit binary number.
- Sits in a pipelined summation tree; one instance per column group.

Parameters:
- PIPE_STAGES, 1, register depth from input to dst.
  - 1: output register only.
  - 2: additional register on intermediate popcounts.
  - Other values are illegal (elaboration error).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies src0/src2 in this cycle.
- src0  input  7  weight-1 bits; each set bit adds 1.
- src2  input  6  weight-4 bits; each set bit adds 4.
- out_valid  output  1  dst holds the result of a valid input.
- dst  output  5  weighted sum, unsigned, 0..31.

Behaviour:
- Function: dst = popcount(src0) + 4*popcount(src2).
  - Max value is 7 + 24 = 31, so the result always fits in 5 bits.
  - No overflow or saturation path is needed.
- Structure:
  - popcount(src0) is 3 bits (0..7), built from full/half adders (e.g., 7:3 counter).
  - popcount(src2) is 3 bits (0..6).
  - Final sum: bits [1:0] = ones-count[1:0].
  - Bits [4:2] = ones-count[2] + twos... concretely dst = {popcnt2,2'b00} + popcnt0, a 5-bit add.
  - Any correct adder structure is acceptable; arithmetic must be exact.
- Pipeline:
  - All registers update on rising clk.
  - Every input presented is computed; there is no backpressure.
  - out_valid is in_valid delayed by PIPE_STAGES cycles.
  - dst is the sum of the src0/src2 sampled PIPE_STAGES cycles earlier.
- Invalid inputs:
  - dst registers load only when the corresponding valid is 1; otherwise they hold their value.
  - out_valid still deasserts.
- Reset:
  - rst_n low asynchronously clears dst to 0, out_valid to 0, and all internal pipeline registers.
  - Effect is immediate, independent of clk.
  - Reset mid-operation discards all in-flight results; no out_valid pulse for them after release.
  - First sample is taken at the first rising clk with rst_n high.
- No X propagation:
  - Outputs are defined at all times after reset.
  - Back-to-back valid inputs every cycle produce back-to-back results in order.

Test Plan:
- Reset: assert rst_n=0 mid-stream with in_valid=1 -> dst=0, out_valid=0 immediately; no stale result appears after release.
- Basic, PIPE_STAGES=1: src0=0x30, src2=0x2b, in_valid=1 -> one cycle later out_valid=1, dst=0x12 (2+16).
- Boundaries:
  - src0=0x7f, src2=0x3f -> dst=0x1f.
  - src0=0x00, src2=0x00 -> dst=0x00.
  - src0=0x1b, src2=0x00 -> dst=0x04.
- Back-to-back streaming: src0=0x62/src2=0x0e, then src0=0x5e/src2=0x2f on consecutive cycles -> dst=0x0f then 0x19 on consecutive cycles, out_valid high both.
- Valid gating: in_valid=0 with src0=0x7f, src2=0x3f after a valid 0x12 result -> dst holds 0x12, out_valid=0.
- PIPE_STAGES=2: repeat the streaming case -> identical values, each delayed two cycles.
- Exhaustive: all 8192 input combinations -> dst equals the reference weighted popcount.
